// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Owner tags, arbiter states and the memory bus address width.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 16;

    typedef enum logic {
        OWN_CORE,
        OWN_HOST
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        CORE,
        HOST,
        HOST_LOCKED
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// Read response tracker: two-stage valid/owner shift register.
// Stage 2 lines up with memory read data arriving one cycle after the address.
module mem_arb_rsp_pipe
    import mem_arb_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_valid,
    input  owner_e i_owner,
    output logic   o_valid,
    output owner_e o_owner
);

    logic   v1;
    owner_e own1;

    // shift the read tag toward the data return cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1      <= 1'b0;
            own1    <= OWN_CORE;
            o_valid <= 1'b0;
            o_owner <= OWN_CORE;
        end else begin
            v1      <= i_valid;
            own1    <= i_owner;
            o_valid <= v1;
            o_owner <= own1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified memory port.
// Round-robin with bounded host burst lock and core code-region write guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16,
    parameter int DATA_BASE = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [ADDR_W-1:0]     i_core_addr,
    input  logic [DATA_W-1:0]     i_core_wdata,
    output logic                  o_core_gnt,
    output logic                  o_core_rvalid,
    output logic [DATA_W-1:0]     o_core_rdata,
    output logic                  o_core_err,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic                  i_host_lock,
    input  logic [ADDR_W-1:0]     i_host_addr,
    input  logic [DATA_W-1:0]     i_host_wdata,
    output logic                  o_host_gnt,
    output logic                  o_host_rvalid,
    output logic [DATA_W-1:0]     o_host_rdata,
    output logic [MEM_ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0]     o_memData,
    output logic                  o_memWrEnable,
    input  logic [DATA_W-1:0]     i_memData
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(DATA_BASE);

    arb_state_e       state;
    arb_state_e       state_nxt;
    owner_e           last_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             core_sel;
    logic             host_sel;
    logic             locked;
    logic             core_bad;
    logic             issue;
    logic             iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    logic             rd_issue;
    owner_e           rd_owner;
    logic             rsp_valid;
    owner_e           rsp_owner;

    // pick at most one requester this cycle
    always_comb begin
        core_sel = 1'b0;
        host_sel = 1'b0;
        locked   = (state == HOST_LOCKED) && i_host_req && i_host_lock;
        if (locked && (burst_cnt < BURST_MAX)) begin
            host_sel = 1'b1;
        end else if (locked && i_core_req) begin
            core_sel = 1'b1;
        end else if (locked) begin
            host_sel = 1'b1;
        end else if (i_core_req && i_host_req) begin
            core_sel = (last_owner == OWN_HOST);
            host_sel = (last_owner == OWN_CORE);
        end else begin
            core_sel = i_core_req;
            host_sel = i_host_req;
        end
    end

    assign o_core_gnt = core_sel & i_rst_n;
    assign o_host_gnt = host_sel & i_rst_n;

    assign core_bad  = o_core_gnt & i_core_we & (i_core_addr < BASE_A);
    assign issue     = (o_core_gnt & ~core_bad) | o_host_gnt;
    assign iss_we    = host_sel ? i_host_we    : i_core_we;
    assign iss_addr  = host_sel ? i_host_addr  : i_core_addr;
    assign iss_wdata = host_sel ? i_host_wdata : i_core_wdata;
    assign rd_issue  = (o_core_gnt & ~i_core_we) | (o_host_gnt & ~i_host_we);
    assign rd_owner  = host_sel ? OWN_HOST : OWN_CORE;

    // next owner state and burst accounting
    always_comb begin
        state_nxt = IDLE;
        burst_nxt = '0;
        if (core_sel) begin
            state_nxt = CORE;
        end else if (host_sel && i_host_lock) begin
            state_nxt = HOST_LOCKED;
            if (i_core_req && (burst_cnt < BURST_MAX)) begin
                burst_nxt = burst_cnt + 1'b1;
            end else begin
                burst_nxt = burst_cnt;
            end
        end else if (host_sel) begin
            state_nxt = HOST;
        end
    end

    // arbiter FSM registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_owner <= OWN_HOST;
            burst_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (core_sel) begin
                last_owner <= OWN_CORE;
            end else if (host_sel) begin
                last_owner <= OWN_HOST;
            end
        end
    end

    // registered memory bus and write-guard error pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_memAddr     <= '0;
            o_memData     <= '0;
            o_memWrEnable <= 1'b0;
            o_core_err    <= 1'b0;
        end else begin
            o_core_err <= core_bad;
            if (issue) begin
                o_memAddr     <= {{(MEM_ADDR_W-ADDR_W){1'b0}}, iss_addr};
                o_memWrEnable <= iss_we;
                o_memData     <= iss_we ? iss_wdata : '0;
            end else begin
                o_memWrEnable <= 1'b0;
                o_memData     <= '0;
            end
        end
    end

    mem_arb_rsp_pipe u_rsp (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_issue),
        .i_owner (rd_owner),
        .o_valid (rsp_valid),
        .o_owner (rsp_owner)
    );

    assign o_core_rvalid = rsp_valid & (rsp_owner == OWN_CORE);
    assign o_host_rvalid = rsp_valid & (rsp_owner == OWN_HOST);
    assign o_core_rdata  = o_core_rvalid ? i_memData : '0;
    assign o_host_rdata  = o_host_rvalid ? i_memData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64-word memory model.
// Expected values are hand-computed per scenario.
module tb_mem_port_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_core_req;
    logic        i_core_we;
    logic [5:0]  i_core_addr;
    logic [15:0] i_core_wdata;
    logic        o_core_gnt;
    logic        o_core_rvalid;
    logic [15:0] o_core_rdata;
    logic        o_core_err;
    logic        i_host_req;
    logic        i_host_we;
    logic        i_host_lock;
    logic [5:0]  i_host_addr;
    logic [15:0] i_host_wdata;
    logic        o_host_gnt;
    logic        o_host_rvalid;
    logic [15:0] o_host_rdata;
    logic [15:0] o_memAddr;
    logic [15:0] o_memData;
    logic        o_memWrEnable;
    logic [15:0] i_memData;

    logic [15:0] mem [64];
    logic        preload;
    int          checks;
    int          errors;

    mem_port_arbiter dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_core_req    (i_core_req),
        .i_core_we     (i_core_we),
        .i_core_addr   (i_core_addr),
        .i_core_wdata  (i_core_wdata),
        .o_core_gnt    (o_core_gnt),
        .o_core_rvalid (o_core_rvalid),
        .o_core_rdata  (o_core_rdata),
        .o_core_err    (o_core_err),
        .i_host_req    (i_host_req),
        .i_host_we     (i_host_we),
        .i_host_lock   (i_host_lock),
        .i_host_addr   (i_host_addr),
        .i_host_wdata  (i_host_wdata),
        .o_host_gnt    (o_host_gnt),
        .o_host_rvalid (o_host_rvalid),
        .o_host_rdata  (o_host_rdata),
        .o_memAddr     (o_memAddr),
        .o_memData     (o_memData),
        .o_memWrEnable (o_memWrEnable),
        .i_memData     (i_memData)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // synchronous memory: read data valid one cycle after the address
    always @(posedge i_clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'(i);
            mem[0] <= 16'h1A47;
        end else if (o_memWrEnable) begin
            mem[o_memAddr[5:0]] <= o_memData;
        end
        i_memData <= mem[o_memAddr[5:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in;
        i_core_req   = 1'b0;
        i_core_we    = 1'b0;
        i_core_addr  = '0;
        i_core_wdata = '0;
        i_host_req   = 1'b0;
        i_host_we    = 1'b0;
        i_host_lock  = 1'b0;
        i_host_addr  = '0;
        i_host_wdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cg"}, 64'(o_core_gnt), 64'd0);
        chk({tag, "_hg"}, 64'(o_host_gnt), 64'd0);
        chk({tag, "_crv"}, 64'(o_core_rvalid), 64'd0);
        chk({tag, "_hrv"}, 64'(o_host_rvalid), 64'd0);
        chk({tag, "_err"}, 64'(o_core_err), 64'd0);
        chk({tag, "_bus"}, {o_memAddr, o_memData, 16'(o_memWrEnable)}, 64'd0);
        chk({tag, "_rd"}, {o_core_rdata, o_host_rdata}, 64'd0);
    endtask

    logic [5:0]  at_addr [4];
    logic [15:0] at_exp  [4];
    logic        at_host [4];

    initial begin
        checks  = 0;
        errors  = 0;
        preload = 1'b1;
        i_rst_n = 1'b0;
        idle_in();
        nxt();
        preload = 1'b0;
        nxt();
        @(negedge i_clk);
        chk_all_zero("rst");

        // single core read of addr 0
        nxt();
        i_rst_n = 1'b1;
        nxt();
        i_core_req = 1'b1;
        i_core_addr = 6'd0;
        @(negedge i_clk);
        chk("rd0_gnt", {o_core_gnt, o_host_gnt}, 64'b10);
        nxt();
        idle_in();
        @(negedge i_clk);
        chk("rd0_bus", {o_memAddr, 15'd0, o_memWrEnable}, 64'd0);
        chk("rd0_early", 64'(o_core_rvalid), 64'd0);
        nxt();
        @(negedge i_clk);
        chk("rd0_rsp", {o_core_rvalid, o_core_rdata, o_host_rvalid}, {1'b1, 16'h1A47, 1'b0});

        // reset while a read is in flight
        nxt();
        i_core_req = 1'b1;
        i_core_addr = 6'd3;
        @(negedge i_clk);
        chk("rd3_gnt", 64'(o_core_gnt), 64'd1);
        nxt();
        idle_in();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk_all_zero("midrst");
        nxt();
        @(negedge i_clk);
        chk("midrst_rv", {o_core_rvalid, o_host_rvalid}, 64'd0);
        nxt();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rv0", {o_core_rvalid, o_host_rvalid}, 64'd0);
        nxt();
        @(negedge i_clk);
        chk("post_rv1", {o_core_rvalid, o_host_rvalid}, 64'd0);

        // both request, no lock: strict alternation from core
        nxt();
        i_core_req = 1'b1;
        i_core_addr = 6'd2;
        i_host_req = 1'b1;
        i_host_addr = 6'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk($sformatf("alt%0d", i), {o_core_gnt, o_host_gnt},
                (i % 2 == 0) ? 64'b10 : 64'b01);
            if (i >= 2) begin
                chk($sformatf("altrsp%0d", i),
                    {o_core_rvalid, o_core_rdata, o_host_rvalid, o_host_rdata},
                    (i % 2 == 0) ? {1'b1, 16'd2, 1'b0, 16'd0}
                                 : {1'b0, 16'd0, 1'b1, 16'd1});
            end
            nxt();
        end
        idle_in();
        repeat (3) nxt();

        // host lock with core waiting: 8 host grants per core grant
        i_core_req = 1'b1;
        i_core_addr = 6'd2;
        i_host_req = 1'b1;
        i_host_lock = 1'b1;
        i_host_addr = 6'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            chk($sformatf("lock%0d", i), {o_core_gnt, o_host_gnt},
                (i == 0 || i == 9 || i == 18) ? 64'b10 : 64'b01);
            nxt();
        end
        i_host_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk($sformatf("unlock%0d", i), {o_core_gnt, o_host_gnt},
                (i % 2 == 0) ? 64'b10 : 64'b01);
            nxt();
        end
        idle_in();
        repeat (3) nxt();

        // core write into code region is dropped
        i_core_req = 1'b1;
        i_core_we = 1'b1;
        i_core_addr = 6'd5;
        i_core_wdata = 16'hBEEF;
        @(negedge i_clk);
        chk("wr5_gnt", 64'(o_core_gnt), 64'd1);
        nxt();
        idle_in();
        @(negedge i_clk);
        chk("wr5_bus", {o_memData, 15'd0, o_memWrEnable}, 64'd0);
        chk("wr5_err", 64'(o_core_err), 64'd1);
        nxt();
        @(negedge i_clk);
        chk("wr5_err_end", 64'(o_core_err), 64'd0);
        chk("wr5_mem", 64'(mem[5]), 64'd5);

        // core write into data region goes through
        nxt();
        i_core_req = 1'b1;
        i_core_we = 1'b1;
        i_core_addr = 6'd40;
        i_core_wdata = 16'hBEEF;
        @(negedge i_clk);
        chk("wr40_gnt", 64'(o_core_gnt), 64'd1);
        nxt();
        idle_in();
        @(negedge i_clk);
        chk("wr40_bus", {o_memAddr, o_memData, 15'd0, o_memWrEnable},
            {16'd40, 16'hBEEF, 16'd1});
        chk("wr40_err", 64'(o_core_err), 64'd0);
        nxt();
        @(negedge i_clk);
        chk("wr40_idle", {o_memData, 15'd0, o_memWrEnable}, 64'd0);

        // host loads 0..31 back-to-back
        nxt();
        for (int i = 0; i < 32; i++) begin
            i_host_req = 1'b1;
            i_host_we = 1'b1;
            i_host_addr = 6'(i);
            i_host_wdata = 16'hA000 + 16'(i);
            @(negedge i_clk);
            chk($sformatf("ld%0d_gnt", i), 64'(o_host_gnt), 64'd1);
            if (i > 0) begin
                chk($sformatf("ld%0d_bus", i - 1),
                    {o_memAddr, o_memData, 15'd0, o_memWrEnable},
                    {16'(i - 1), 16'hA000 + 16'(i - 1), 16'd1});
            end
            nxt();
        end
        idle_in();
        @(negedge i_clk);
        chk("ld31_bus", {o_memAddr, o_memData, 15'd0, o_memWrEnable},
            {16'd31, 16'hA01F, 16'd1});
        nxt();
        @(negedge i_clk);
        chk("ld_idle", {o_memAddr, o_memData, 15'd0, o_memWrEnable},
            {16'd31, 16'd0, 16'd0});

        // host reads back addr 40
        nxt();
        i_host_req = 1'b1;
        i_host_addr = 6'd40;
        @(negedge i_clk);
        chk("hrd40_gnt", {o_core_gnt, o_host_gnt}, 64'b01);
        nxt();
        idle_in();
        @(negedge i_clk);
        chk("hrd40_addr", 64'(o_memAddr), 64'd40);
        nxt();
        @(negedge i_clk);
        chk("hrd40_rsp",
            {o_core_rvalid, o_core_rdata, o_host_rvalid, o_host_rdata},
            {1'b0, 16'd0, 1'b1, 16'hBEEF});

        // alternating single reads, responses routed by owner
        at_addr = '{6'd0, 6'd40, 6'd31, 6'd1};
        at_exp  = '{16'hA000, 16'hBEEF, 16'hA01F, 16'hA001};
        at_host = '{1'b0, 1'b1, 1'b0, 1'b1};
        nxt();
        for (int k = 0; k < 6; k++) begin
            idle_in();
            if (k < 4) begin
                if (at_host[k]) begin
                    i_host_req = 1'b1;
                    i_host_addr = at_addr[k];
                end else begin
                    i_core_req = 1'b1;
                    i_core_addr = at_addr[k];
                end
            end
            @(negedge i_clk);
            if (k < 4) begin
                chk($sformatf("ar%0d_gnt", k), {o_core_gnt, o_host_gnt},
                    at_host[k] ? 64'b01 : 64'b10);
            end
            if (k >= 2) begin
                chk($sformatf("ar%0d_rsp", k - 2),
                    {o_core_rvalid, o_core_rdata, o_host_rvalid, o_host_rdata},
                    at_host[k - 2] ? {1'b0, 16'd0, 1'b1, at_exp[k - 2]}
                                   : {1'b1, at_exp[k - 2], 1'b0, 16'd0});
            end
            nxt();
        end
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 64-word unified memory port between two requesters: the core (instruction fetch, operand read, result write-back) and a host loader/debug port (program load, result readback).
- Sits between the core/host and the memory model.
- Drives the same memory bus the core drives today: i_memData, o_memData, o_memAddr, o_memWrEnable.
- Provides round-robin arbitration, bounded host burst lock, and core write protection of the instruction region.

Parameters:
ADDR_W, 6, requester-side word address width
DATA_W, 16, data width
DATA_BASE, 32, first data-region address; core writes below this are rejected
MAX_BURST, 8, max consecutive locked host grants while core is waiting

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_core_req  in  1  core transfer request
i_core_we  in  1  1 = write, 0 = read
i_core_addr  in  ADDR_W  core word address
i_core_wdata  in  DATA_W  core write data
o_core_gnt  out  1  core transfer accepted this cycle
o_core_rvalid  out  1  core read data valid
o_core_rdata  out  DATA_W  core read data
o_core_err  out  1  one-cycle pulse: core write to addr < DATA_BASE dropped
i_host_req  in  1  host transfer request
i_host_we  in  1  host write enable
i_host_lock  in  1  host requests to keep ownership
i_host_addr  in  ADDR_W  host word address
i_host_wdata  in  DATA_W  host write data
o_host_gnt  out  1  host transfer accepted this cycle
o_host_rvalid  out  1  host read data valid
o_host_rdata  out  DATA_W  host read data
o_memAddr  out  16  memory address, zero-extended from ADDR_W
o_memData  out  DATA_W  memory write data
o_memWrEnable  out  1  memory write strobe
i_memData  in  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Reset (async assert, sync release): every output is 0; state = IDLE; last_owner = HOST, so core wins the first tie; burst_cnt = 0; response pipeline is flushed.
- Reset mid-transfer discards the in-flight rvalid. No response is produced after reset.
- Handshake:
  - gnt is combinational from req and state.
  - A transfer occurs when req && gnt.
  - At most one gnt per cycle; no gnt without req.
  - Requester holds addr/we/wdata stable until granted.
- Memory side is registered. A transfer accepted in cycle N drives o_memAddr/o_memWrEnable/o_memData in N+1.
- o_memData = 0 and o_memWrEnable = 0 in any cycle without an issued write. o_memAddr holds its last value when idle.
- Reads: o_X_rvalid = 1 in N+2 with o_X_rdata = i_memData. The owner tag is pipelined alongside. The non-owner's rdata = 0. Throughput is 1 transfer/cycle, back-to-back.
- FSM states: IDLE, CORE, HOST, HOST_LOCKED. The state records the current cycle's owner.
  - Only one requests: grant it.
  - Both request, not locked: grant the opposite of last_owner.
  - HOST_LOCKED: host is granted while i_host_req && i_host_lock && burst_cnt < MAX_BURST.
  - burst_cnt increments only on locked grants while i_core_req = 1.
  - At burst_cnt == MAX_BURST with core requesting: grant core one transfer, clear burst_cnt, then return to HOST_LOCKED if the lock is still held.
  - Lock dropped or host idle: exit to IDLE/CORE and clear burst_cnt.
  - No requests: IDLE.
- Core write protection:
  - Core write with addr < DATA_BASE: gnt = 1 (consumed), no memory write issued, o_core_err = 1 in N+1.
  - Core reads anywhere are allowed.
  - Host writes anywhere.
- Simultaneous events: core error and host grant cannot coincide, because one gnt per cycle.

Decomposition:
- Package mem_arb_pkg:
  - owner_e {OWN_CORE, OWN_HOST}
  - arb_state_e {IDLE, CORE, HOST, HOST_LOCKED}
  - MEM_ADDR_W = 16
- Sub-module mem_arb_rsp_pipe: 2-stage valid/owner shift register with async reset, producing the rvalid routing.

Test Plan:
- Reset, then core reads addr 0 (mem[0] = 16'h1A47): o_core_gnt in cycle 0, o_memAddr = 16'h0000 in cycle 1, o_core_rvalid with rdata 16'h1A47 in cycle 2. Assert i_rst_n low at cycle 1 of a second read: no rvalid follows, all outputs 0.
- Both request continuously, no lock: grants alternate core, host, core, host. First grant goes to core.
- Host lock with core requesting for 20 cycles, MAX_BURST = 8: 8 host grants, 1 core grant, 8 host grants, 1 core grant, and so on. Drop the lock: strict alternation resumes.
- Core write addr 5, data 16'hBEEF: gnt = 1, o_memWrEnable stays 0, o_core_err pulses in the next cycle, mem[5] unchanged. Core write addr 40, data 16'hBEEF: o_memWrEnable = 1, o_memAddr = 40, o_memData = 16'hBEEF.
- Host loads addr 0..31 back-to-back, then reads 40: 32 consecutive write cycles with o_memData = 0 on the first idle cycle afterwards. The read returns in host rdata only; o_core_rvalid stays 0.
- Alternating core read / host read back-to-back: each rvalid goes to the correct requester with the matching data, 2 cycles after its grant.
